// File: rtl/video_mode_sequencer.sv
// Mode-change controller: debounces a requested mode index, then walks the timing
// generator and pixel-clock PLL through blank -> reconfigure -> settle before switching.
`ifndef MODE_SIZE
`define MODE_SIZE 4
`endif

typedef struct packed {
  logic [15:0] h_active;
  logic [15:0] v_active;
  logic [15:0] h_total;
  logic [15:0] v_total;
  logic [31:0] pixel_khz;
} VideoMode;

module video_mode_sequencer #(
  parameter int MODE_SIZE     = `MODE_SIZE,
  parameter int NUM_MODES     = 16,
  parameter int STABLE_CYCLES = 1024,
  parameter int BLANK_CYCLES  = 4,
  parameter int SETTLE_CYCLES = 256,
  parameter int ACK_TIMEOUT   = 65535
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [MODE_SIZE-1:0] data_in,
  input  logic                 reconfig_ack,
  output VideoMode             videoMode,
  output logic [MODE_SIZE-1:0] active_mode,
  output logic                 video_enable,
  output logic                 reconfig_req,
  output logic                 mode_changed,
  output logic                 error
);

  // Mode table entries step up in resolution with fixed blanking at 60 Hz refresh.
  function automatic VideoMode mode_entry(input int idx);
    VideoMode m;
    int ha, va, ht, vt;
    ha = 640 + 80 * idx;
    va = 480 + 45 * idx;
    ht = ha + 160;
    vt = va + 45;
    m.h_active  = 16'(ha);
    m.v_active  = 16'(va);
    m.h_total   = 16'(ht);
    m.v_total   = 16'(vt);
    m.pixel_khz = 32'((ht * vt * 60) / 1000);
    return m;
  endfunction

  localparam int TABLE_SIZE = 2 ** MODE_SIZE;
  localparam int STABLE_W   = $clog2(STABLE_CYCLES + 1);
  localparam int BLANK_W    = $clog2(BLANK_CYCLES + 1);
  localparam int SETTLE_W   = $clog2(SETTLE_CYCLES + 1);
  localparam int ACK_W      = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;

  localparam logic [STABLE_W-1:0]  STABLE_MAX  = STABLE_W'(STABLE_CYCLES);
  localparam logic [BLANK_W-1:0]   BLANK_LAST  = BLANK_W'(BLANK_CYCLES - 1);
  localparam logic [SETTLE_W-1:0]  SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [ACK_W-1:0]     ACK_LAST    = ACK_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);
  localparam logic [MODE_SIZE:0]   NUM_MODES_L = (MODE_SIZE + 1)'(NUM_MODES);
  localparam VideoMode             MODE0       = mode_entry(0);

  typedef enum logic [2:0] {INIT, RUN, BLANK, RECONF, SETTLE} state_t;

  state_t               state_reg, state_next;
  logic [MODE_SIZE-1:0] req_reg, pending_reg, active_reg;
  logic [STABLE_W-1:0]  stable_cnt_reg;
  logic [BLANK_W-1:0]   blank_cnt_reg;
  logic [SETTLE_W-1:0]  settle_cnt_reg;
  logic [ACK_W-1:0]     ack_cnt_reg;
  VideoMode             video_mode_reg;
  logic                 video_enable_reg, reconfig_req_reg, mode_changed_reg, error_reg;

  logic stable, req_valid, candidate, evaluating;
  logic accept, ack_taken, ack_expired, bad_request, run_entry;

  // Indices past NUM_MODES are never applied; they alias entry 0 so the index width matches.
  VideoMode mode_table [TABLE_SIZE];
  for (genvar gi = 0; gi < TABLE_SIZE; gi++) begin : g_table
    assign mode_table[gi] = (gi < NUM_MODES) ? mode_entry(gi) : MODE0;
  end

  assign stable      = (stable_cnt_reg == STABLE_MAX);
  assign req_valid   = ({1'b0, req_reg} < NUM_MODES_L);
  assign evaluating  = (state_reg == INIT) || (state_reg == RUN);
  assign candidate   = stable && req_valid && (req_reg != active_reg);
  assign accept      = evaluating && (state_next == BLANK);
  assign ack_taken   = (state_reg == RECONF) && reconfig_ack;
  assign ack_expired = (state_reg == RECONF) && !reconfig_ack && (ack_cnt_reg == ACK_LAST);
  assign bad_request = evaluating && stable && !req_valid;
  assign run_entry   = (state_reg == SETTLE) && (state_next == RUN);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      INIT:    if (stable && req_valid) state_next = BLANK;
      RUN:     if (candidate) state_next = BLANK;
      BLANK:   if (blank_cnt_reg == BLANK_LAST) state_next = RECONF;
      // An ack on the expiry cycle still completes the change.
      RECONF: begin
        if (reconfig_ack) state_next = SETTLE;
        else if (ack_expired) state_next = BLANK;
      end
      SETTLE:  if (settle_cnt_reg == SETTLE_LAST) state_next = RUN;
      default: state_next = INIT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg        <= INIT;
      req_reg          <= '0;
      stable_cnt_reg   <= '0;
      blank_cnt_reg    <= '0;
      settle_cnt_reg   <= '0;
      ack_cnt_reg      <= '0;
      pending_reg      <= '0;
      active_reg       <= '0;
      video_mode_reg   <= MODE0;
      video_enable_reg <= 1'b0;
      reconfig_req_reg <= 1'b0;
      mode_changed_reg <= 1'b0;
      error_reg        <= 1'b0;
    end else begin
      state_reg <= state_next;
      req_reg   <= data_in;
      if (data_in != req_reg) stable_cnt_reg <= '0;
      else if (!stable) stable_cnt_reg <= stable_cnt_reg + 1'b1;

      blank_cnt_reg  <= (state_reg == BLANK  && state_next == BLANK)  ? blank_cnt_reg + 1'b1  : '0;
      settle_cnt_reg <= (state_reg == SETTLE && state_next == SETTLE) ? settle_cnt_reg + 1'b1 : '0;
      ack_cnt_reg    <= (state_reg == RECONF && state_next == RECONF) ? ack_cnt_reg + 1'b1    : '0;

      if (accept) pending_reg <= req_reg;
      if (ack_taken) begin
        active_reg     <= pending_reg;
        video_mode_reg <= mode_table[pending_reg];
      end

      video_enable_reg <= (state_next == RUN);
      reconfig_req_reg <= (state_next == RECONF);
      mode_changed_reg <= run_entry;
      if (run_entry) error_reg <= 1'b0;
      else if (ack_expired || bad_request) error_reg <= 1'b1;
    end
  end

  assign videoMode    = video_mode_reg;
  assign active_mode  = active_reg;
  assign video_enable = video_enable_reg;
  assign reconfig_req = reconfig_req_reg;
  assign mode_changed = mode_changed_reg;
  assign error        = error_reg;

endmodule

// File: tb/tb_video_mode_sequencer.sv
// Scoreboarded bench for video_mode_sequencer: directed scenarios plus randomized mode
// requests, with expected mode changes predicted from the request timing rules.
module tb_video_mode_sequencer;
  localparam int MS  = 5;
  localparam int NM  = 16;
  localparam int SC  = 1024;
  localparam int BC  = 4;
  localparam int STC = 256;
  localparam int AT  = 100;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          reconfig_ack = 1'b0;
  logic [MS-1:0] data_in = '0;
  logic [95:0]   video_mode_bus;
  logic [MS-1:0] active_mode;
  logic          video_enable, reconfig_req, mode_changed, error;

  video_mode_sequencer #(
    .MODE_SIZE(MS), .NUM_MODES(NM), .STABLE_CYCLES(SC),
    .BLANK_CYCLES(BC), .SETTLE_CYCLES(STC), .ACK_TIMEOUT(AT)
  ) dut (
    .clock(clock), .reset(reset), .data_in(data_in), .reconfig_ack(reconfig_ack),
    .videoMode(video_mode_bus), .active_mode(active_mode), .video_enable(video_enable),
    .reconfig_req(reconfig_req), .mode_changed(mode_changed), .error(error)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int mode;
    int rise_cyc;
    int ack_cyc;
    int run_cyc;
    bit chk_ack;
  } exp_t;
  exp_t sb_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int model_active = 0;
  bit model_error = 0;
  bit model_init = 1;
  int model_run_edge = -1;
  int last_run = 0;
  int ack_delay = 0;
  int ack_skip = 0;
  int resp_rise, resp_n;

  // Expected table: resolution grows 80x45 per index, 160/45 blanking, 60 Hz pixel rate in kHz.
  function automatic logic [95:0] ref_mode(input int i);
    int w, h, wt, ht, khz;
    w = 640 + 80 * i;
    h = 480 + 45 * i;
    wt = w + 160;
    ht = h + 45;
    khz = wt * ht * 60 / 1000;
    return {16'(w), 16'(h), 16'(wt), 16'(ht), 32'(khz)};
  endfunction

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Request m first sampled on edge c+1; d = ack delay after reconfig_req rises, k = ignored RECONF windows.
  task automatic predict(input int m, input int c, input int d, input int k);
    int stable_edge, blank_edge;
    exp_t e;
    stable_edge = c + 1 + SC;
    if (m >= NM) begin
      model_error = 1;
      return;
    end
    if (!model_init && m == model_active) return;
    blank_edge = ((stable_edge > model_run_edge) ? stable_edge : model_run_edge) + 1;
    e.mode     = m;
    e.rise_cyc = blank_edge + BC + k * (AT + BC);
    e.ack_cyc  = e.rise_cyc + d + 1;
    e.run_cyc  = e.ack_cyc + STC;
    e.chk_ack  = (m != model_active);
    sb_q.push_back(e);
    model_active   = m;
    model_error    = 0;
    model_init     = 0;
    model_run_edge = e.run_cyc;
    last_run       = e.run_cyc;
  endtask

  task automatic drive(input int m, input int d, input int k);
    @(negedge clock);
    data_in   = MS'(m);
    ack_delay = d;
    ack_skip  = k;
    $display("request mode %0d at cycle %0d (ack delay %0d, skipped acks %0d)", m, cyc, d, k);
    predict(m, cyc, d, k);
  endtask

  task automatic wait_reconf(input string tag);
    int n;
    n = 0;
    while (reconfig_req !== 1'b1 && n < SC + 300) begin
      @(negedge clock);
      n++;
    end
    check({tag, "_reconfig_req_seen"}, reconfig_req, 1'b1);
  endtask

  task automatic settle_and_check(input string tag);
    if (sb_q.size() > 0) begin
      while (sb_q.size() > 0 && cyc <= last_run + 4) @(negedge clock);
      if (sb_q.size() > 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL %s_missing_event: got no mode_changed, expected %0d more", tag, sb_q.size());
        sb_q.delete();
      end
      repeat (4) @(negedge clock);
    end else begin
      repeat (SC + 10) @(negedge clock);
    end
    check({tag, "_active_mode"}, active_mode, model_active);
    check({tag, "_error"}, error, model_error);
    check({tag, "_video_enable"}, video_enable, 1'b1);
    check({tag, "_videoMode"}, video_mode_bus, ref_mode(model_active));
  endtask

  // Monitor: every mode_changed pulse must match the oldest expected mode change.
  initial begin : monitor
    logic prev_req;
    logic [MS-1:0] prev_act;
    int last_rise, last_chg;
    exp_t e;
    prev_req = 1'b0;
    prev_act = '0;
    last_rise = 0;
    last_chg = 0;
    forever begin
      @(negedge clock);
      if (reconfig_req === 1'b1 && prev_req !== 1'b1) last_rise = cyc;
      if (active_mode !== prev_act) last_chg = cyc;
      prev_req = reconfig_req;
      prev_act = active_mode;
      if (mode_changed === 1'b1) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_mode_changed: got pulse with mode %0d at cycle %0d, expected none",
                   active_mode, cyc);
        end else begin
          e = sb_q.pop_front();
          $display("mode_changed: mode %0d at cycle %0d (expected mode %0d at %0d)",
                   active_mode, cyc, e.mode, e.run_cyc);
          check("evt_active_mode", active_mode, e.mode);
          check("evt_videoMode", video_mode_bus, ref_mode(e.mode));
          check("evt_video_enable", video_enable, 1'b1);
          check("evt_error_cleared", error, 1'b0);
          check("evt_run_cycle", cyc, e.run_cyc);
          check("evt_req_rise_cycle", last_rise, e.rise_cyc);
          if (e.chk_ack) check("evt_mode_update_cycle", last_chg, e.ack_cyc);
        end
      end
    end
  end

  // PLL model: acks ack_delay cycles after reconfig_req rises, or lets ack_skip windows time out.
  initial begin : responder
    forever begin
      @(negedge clock);
      if (reconfig_req === 1'b1 && reset === 1'b0) begin
        resp_rise = cyc;
        if (ack_skip > 0) begin
          ack_skip = ack_skip - 1;
          resp_n = 0;
          while (reconfig_req === 1'b1 && resp_n < AT + 8) begin
            @(negedge clock);
            resp_n++;
          end
          check("timeout_req_drop_cycle", cyc, resp_rise + AT);
          check("timeout_error_set", error, 1'b1);
        end else begin
          resp_n = 0;
          while (reconfig_req === 1'b1 && resp_n < ack_delay) begin
            @(negedge clock);
            resp_n++;
          end
          if (reconfig_req === 1'b1) begin
            reconfig_ack = 1'b1;
            @(negedge clock);
            reconfig_ack = 1'b0;
          end
        end
        resp_n = 0;
        while (reconfig_req === 1'b1 && resp_n < 2 * AT) begin
          @(negedge clock);
          resp_n++;
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int m, prev, h, kind;
    repeat (4) @(negedge clock);
    check("rst_active_mode", active_mode, 0);
    check("rst_videoMode", video_mode_bus, ref_mode(0));
    check("rst_video_enable", video_enable, 1'b0);
    check("rst_reconfig_req", reconfig_req, 1'b0);
    check("rst_mode_changed", mode_changed, 1'b0);
    check("rst_error", error, 1'b0);

    // First mode from INIT: data_in differs from the reset value of the request register.
    data_in = 3;
    ack_delay = 9;
    ack_skip = 0;
    @(negedge clock);
    reset = 1'b0;
    $display("release reset with request 3 at cycle %0d", cyc);
    predict(3, cyc, 9, 0);
    settle_and_check("init3");

    // Glitchy request: 500-cycle toggles never become stable.
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      data_in = (i % 2 == 0) ? 5 : 3;
      repeat (499) @(negedge clock);
    end
    drive(5, 20, 0);
    settle_and_check("glitch5");

    drive(3, 5, 0);
    settle_and_check("back3");
    drive(20, 0, 0);
    settle_and_check("invalid20");

    drive(9, 20, 2);
    settle_and_check("timeout9");

    // Request changes while the 3 sequence is in RECONF.
    drive(3, 30, 0);
    wait_reconf("mid");
    drive(7, 30, 0);
    settle_and_check("mid7");

    // Reset during RECONF.
    drive(12, 50, 0);
    wait_reconf("rst_mid");
    reset = 1'b1;
    sb_q.delete();
    data_in = 0;
    @(negedge clock);
    check("rst_mid_reconfig_req", reconfig_req, 1'b0);
    check("rst_mid_active_mode", active_mode, 0);
    check("rst_mid_video_enable", video_enable, 1'b0);
    check("rst_mid_error", error, 1'b0);
    check("rst_mid_videoMode", video_mode_bus, ref_mode(0));
    repeat (3) @(negedge clock);
    ack_delay = 12;
    ack_skip = 0;
    model_init = 1;
    model_active = 0;
    model_error = 0;
    model_run_edge = -1;
    reset = 1'b0;
    $display("release reset with request 0 at cycle %0d", cyc);
    // data_in already equals the reset request register, so counting starts on the first edge.
    predict(0, cyc - 1, 12, 0);
    settle_and_check("init0");

    prev = 0;
    for (int i = 0; i < 12; i++) begin
      kind = $urandom_range(0, 19);
      if (kind >= 17) begin
        for (int g = 0; g < 2; g++) begin
          do m = $urandom_range(0, 31); while (m == prev);
          h = $urandom_range(1, SC - 1);
          @(negedge clock);
          data_in = MS'(m);
          prev = m;
          repeat (h - 1) @(negedge clock);
        end
      end
      do m = (kind >= 14 && kind < 17) ? $urandom_range(NM, 31) : $urandom_range(0, NM - 1);
      while (m == prev);
      prev = m;
      drive(m, $urandom_range(0, 60), ($urandom_range(0, 4) == 0) ? 1 : 0);
      settle_and_check("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
